// File: rtl/frameblock_pkg.sv
// Shared types and helpers for the frameblock pool.
// Holds the per-buffer state enum, default widths, buffer-count limit,
// and the index FIFO used for the free list, display queue and dirty FIFO.
package frameblock_pkg;

    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_ADDR_W   = 10;
    localparam int unsigned DEF_ID_W     = 7;
    localparam int unsigned MAX_NUM_BUFS = 8;
    localparam int unsigned IDX_MAX_W    = $clog2(MAX_NUM_BUFS);
    localparam int unsigned CNT_W        = IDX_MAX_W + 1;

    typedef enum logic [2:0] {
        BUF_FREE    = 3'd0,
        BUF_DRAW    = 3'd1,
        BUF_QUEUED  = 3'd2,
        BUF_DISPLAY = 3'd3,
        BUF_DIRTY   = 3'd4
    } buf_state_e;

    // Index FIFO: slot[0] is the head, entries shift down on pop.
    typedef struct packed {
        logic [MAX_NUM_BUFS-1:0][IDX_MAX_W-1:0] slot;
        logic [CNT_W-1:0]                       count;
    } idx_fifo_t;

    // Buffer-index width for a given buffer count.
    function automatic int unsigned idx_width(input int unsigned num_bufs);
        return (num_bufs < 2) ? 1 : $clog2(num_bufs);
    endfunction

    // Next FIFO value; pop uses the pre-edge contents, push is never bypassed.
    function automatic idx_fifo_t fifo_update(input idx_fifo_t f, input logic pop,
                                              input logic push,
                                              input logic [IDX_MAX_W-1:0] din);
        idx_fifo_t r;
        r = f;
        if (pop) begin
            for (int unsigned i = 0; i < MAX_NUM_BUFS - 1; i++) begin
                r.slot[i] = f.slot[i+1];
            end
            r.count = f.count - CNT_W'(1);
        end
        if (push) begin
            r.slot[r.count[IDX_MAX_W-1:0]] = din;
            r.count = r.count + CNT_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read, 1-cycle latency,
// returns old data on a same-address write).
module fb_dpram
    import frameblock_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frameblock_pool.sv
// N-buffer frameblock manager between the triangle drawing controller and
// the display output controller. Buffers circulate free -> draw -> queued ->
// display -> (dirty ->) free.
// Ports: clk, rst (sync, active high); draw side write/read port, draw_id,
// draw_next, draw_ready; display side read port, display_id, display_next,
// display_ready; busy (clear engine active).
// Optional feature macro: FRAMEBLOCK_POOL_CLEAR_EN adds a clear engine that
// fills each released buffer with CLEAR_VALUE before it is reused.
module frameblock_pool
    import frameblock_pkg::*;
#(
    parameter int unsigned       DATA_W      = DEF_DATA_W,
    parameter int unsigned       ADDR_W      = DEF_ADDR_W,
    parameter int unsigned       ID_W        = DEF_ID_W,
    parameter int unsigned       NUM_BUFS    = 3,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] draw_wrdata,
    input  logic [ADDR_W-1:0] draw_wraddr,
    input  logic              draw_we,
    input  logic [ADDR_W-1:0] draw_rdaddr,
    output logic [DATA_W-1:0] draw_rddata,
    input  logic [ID_W-1:0]   draw_id,
    input  logic              draw_next,
    output logic              draw_ready,
    input  logic [ADDR_W-1:0] display_rdaddr,
    output logic [DATA_W-1:0] display_rddata,
    output logic [ID_W-1:0]   display_id,
    input  logic              display_next,
    output logic              display_ready,
    output logic              busy
);

    localparam int unsigned IDX_W = idx_width(NUM_BUFS);
    typedef logic [IDX_W-1:0] idx_t;

    buf_state_e        state_q [NUM_BUFS];
    buf_state_e        state_d [NUM_BUFS];
    logic [ID_W-1:0]   id_q    [NUM_BUFS];
    logic [ID_W-1:0]   id_d    [NUM_BUFS];
    idx_t              draw_buf_q, draw_buf_d, disp_buf_q, disp_buf_d;
    logic              draw_ready_q, draw_ready_d, display_ready_q, display_ready_d;
    logic [ID_W-1:0]   display_id_q, display_id_d;
    idx_fifo_t         free_q, free_d, queue_q, queue_d;
    logic              draw_acc, disp_acc, draw_grant, disp_grant;

    logic [NUM_BUFS-1:0] clr_we;
    logic [ADDR_W-1:0]   clr_waddr;
    logic [DATA_W-1:0]   ram_q [NUM_BUFS];
    idx_t                draw_sel_q, disp_sel_q;
    logic                rd_valid_q;

`ifdef FRAMEBLOCK_POOL_CLEAR_EN
    idx_fifo_t         dirty_q, dirty_d;
    logic              clr_active_q, clr_active_d;
    idx_t              clr_buf_q, clr_buf_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_done, clr_start, clr_take_head;
`endif

    // Ownership bookkeeping: accepts, grants and FIFO movement.
    always_comb begin
        state_d         = state_q;
        id_d            = id_q;
        draw_buf_d      = draw_buf_q;
        disp_buf_d      = disp_buf_q;
        draw_ready_d    = draw_ready_q;
        display_ready_d = display_ready_q;
        display_id_d    = display_id_q;

        draw_acc   = draw_next && draw_ready_q;
        disp_acc   = display_next && display_ready_q;
        draw_grant = !draw_ready_q && (free_q.count != '0);
        disp_grant = !display_ready_q && (queue_q.count != '0);

        if (draw_acc) begin
            id_d[draw_buf_q]    = draw_id;
            state_d[draw_buf_q] = BUF_QUEUED;
            draw_ready_d        = 1'b0;
        end
        if (draw_grant) begin
            draw_buf_d          = idx_t'(free_q.slot[0]);
            state_d[draw_buf_d] = BUF_DRAW;
            draw_ready_d        = 1'b1;
        end
        if (disp_acc) begin
            state_d[disp_buf_q] = BUF_FREE;
            display_ready_d     = 1'b0;
        end
        if (disp_grant) begin
            disp_buf_d          = idx_t'(queue_q.slot[0]);
            state_d[disp_buf_d] = BUF_DISPLAY;
            display_id_d        = id_q[disp_buf_d];
            display_ready_d     = 1'b1;
        end

        queue_d = fifo_update(queue_q, disp_grant, draw_acc, IDX_MAX_W'(draw_buf_q));

`ifdef FRAMEBLOCK_POOL_CLEAR_EN
        clr_active_d = clr_active_q;
        clr_buf_d    = clr_buf_q;
        clr_addr_d   = clr_addr_q;

        if (disp_acc) begin
            state_d[disp_buf_q] = BUF_DIRTY;
        end

        // Engine can take new work on the edge that finishes the current block;
        // with an empty dirty FIFO a just-released buffer goes straight in.
        clr_done      = clr_active_q && (clr_addr_q == '1);
        clr_take_head = dirty_q.count != '0;
        clr_start     = (!clr_active_q || clr_done) && (clr_take_head || disp_acc);

        dirty_d = fifo_update(dirty_q, clr_start && clr_take_head,
                              disp_acc && !(clr_start && !clr_take_head),
                              IDX_MAX_W'(disp_buf_q));
        free_d  = fifo_update(free_q, draw_grant, clr_done, IDX_MAX_W'(clr_buf_q));

        if (clr_done) begin
            state_d[clr_buf_q] = BUF_FREE;
            clr_active_d       = 1'b0;
        end
        if (clr_start) begin
            clr_active_d = 1'b1;
            clr_addr_d   = '0;
            clr_buf_d    = clr_take_head ? idx_t'(dirty_q.slot[0]) : disp_buf_q;
        end else if (clr_active_q) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
`else
        free_d = fifo_update(free_q, draw_grant, disp_acc, IDX_MAX_W'(disp_buf_q));
`endif
    end

    // Ownership registers and read-select pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_BUFS; i++) begin
                state_q[i] <= (i == 0) ? BUF_DRAW : BUF_FREE;
                id_q[i]    <= '0;
            end
            draw_buf_q      <= '0;
            disp_buf_q      <= '0;
            draw_ready_q    <= 1'b1;
            display_ready_q <= 1'b0;
            display_id_q    <= '0;
            queue_q         <= '0;
            free_q          <= '0;
            for (int unsigned i = 1; i < NUM_BUFS; i++) begin
                free_q.slot[i-1] <= IDX_MAX_W'(i);
            end
            free_q.count    <= CNT_W'(NUM_BUFS - 1);
            draw_sel_q      <= '0;
            disp_sel_q      <= '0;
            rd_valid_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            id_q            <= id_d;
            draw_buf_q      <= draw_buf_d;
            disp_buf_q      <= disp_buf_d;
            draw_ready_q    <= draw_ready_d;
            display_ready_q <= display_ready_d;
            display_id_q    <= display_id_d;
            queue_q         <= queue_d;
            free_q          <= free_d;
            // Remember the owner at address time so data follows it one cycle later.
            draw_sel_q      <= draw_buf_q;
            disp_sel_q      <= disp_buf_q;
            rd_valid_q      <= 1'b1;
        end
    end

`ifdef FRAMEBLOCK_POOL_CLEAR_EN
    // Clear engine registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty_q      <= '0;
            clr_active_q <= 1'b0;
            clr_buf_q    <= '0;
            clr_addr_q   <= '0;
        end else begin
            dirty_q      <= dirty_d;
            clr_active_q <= clr_active_d;
            clr_buf_q    <= clr_buf_d;
            clr_addr_q   <= clr_addr_d;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_BUFS; i++) begin
            clr_we[i] = clr_active_q && (clr_buf_q == idx_t'(i));
        end
        clr_waddr = clr_addr_q;
    end

    assign busy = clr_active_q;
`else
    assign clr_we    = '0;
    assign clr_waddr = '0;
    assign busy      = 1'b0;
`endif

    // Per-buffer RAM with write-port and read-address muxing by ownership.
    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_buf
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic [ADDR_W-1:0] raddr;

        always_comb begin
            we    = !rst && ((state_q[g] == BUF_DRAW && draw_we) || clr_we[g]);
            waddr = clr_we[g] ? clr_waddr : draw_wraddr;
            wdata = clr_we[g] ? CLEAR_VALUE : draw_wrdata;
            raddr = (state_q[g] == BUF_DISPLAY) ? display_rdaddr : draw_rdaddr;
        end

        fb_dpram #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk   (clk),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .raddr (raddr),
            .rdata (ram_q[g])
        );
    end

    assign draw_rddata    = rd_valid_q ? ram_q[draw_sel_q] : '0;
    assign display_rddata = rd_valid_q ? ram_q[disp_sel_q] : '0;
    assign draw_ready     = draw_ready_q;
    assign display_ready  = display_ready_q;
    assign display_id     = display_id_q;

endmodule
